// File: rtl/stim_sequencer.sv
// stim_sequencer: steps an N-bit stimulus vector through one of four
// sequence modes, holding each vector for HOLD cycles, and counts how many
// windows ended with resp=1. Intended to exhaustively exercise a small
// combinational block on hardware and report a truth-table signature.
module stim_sequencer #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             resp,
  output logic [WIDTH-1:0] vec,
  output logic             vec_valid,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count
);

  // Hold counter needs at least one bit even when HOLD=1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] idx_reg;
  logic [HW-1:0]    hcnt_reg;
  logic [1:0]       mode_reg;
  logic [WIDTH:0]   ones_reg;

  logic             sample_hit;
  logic [WIDTH-1:0] last_idx;
  logic [WIDTH-1:0] vec_raw;

  // End of the current hold window, and the index of the final vector.
  // Walking-one visits WIDTH vectors; every other mode visits 2^WIDTH.
  assign sample_hit = (hcnt_reg == HW'(HOLD - 1));
  assign last_idx   = (mode_reg == 2'b10) ? WIDTH'(WIDTH - 1) : '1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: stop beats completion; start only counts outside RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = RUN;
      RUN: begin
        if (stop)                                 state_next = IDLE;
        else if (sample_hit && idx_reg == last_idx) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: index/hold counters and the ones accumulator.
  // An aborted sample cycle is deliberately not accumulated.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg  <= '0;
      hcnt_reg <= '0;
      mode_reg <= 2'b00;
      ones_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            mode_reg <= mode;
            idx_reg  <= '0;
            hcnt_reg <= '0;
            ones_reg <= '0;
          end
        end
        RUN: begin
          if (!stop) begin
            if (sample_hit) begin
              ones_reg <= ones_reg + {{WIDTH{1'b0}}, resp};
              hcnt_reg <= '0;
              if (idx_reg != last_idx) idx_reg <= idx_reg + WIDTH'(1);
            end else begin
              hcnt_reg <= hcnt_reg + HW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Vector pattern as a pure function of the latched mode and index.
  always_comb begin
    vec_raw = idx_reg;
    case (mode_reg)
      2'b00: vec_raw = idx_reg;
      2'b01: vec_raw = idx_reg ^ (idx_reg >> 1);
      2'b10: vec_raw = WIDTH'(1) << idx_reg;
      2'b11: vec_raw = ~idx_reg;
      default: vec_raw = idx_reg;
    endcase
  end

  // Output decode: vector and strobes are only live in RUN.
  always_comb begin
    vec       = '0;
    vec_valid = 1'b0;
    sample    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      RUN: begin
        vec       = vec_raw;
        vec_valid = 1'b1;
        sample    = sample_hit;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign ones_count = ones_reg;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: two instances (WIDTH=2/HOLD=4 and
// WIDTH=3/HOLD=1). Stimulus pushes expected sample vectors and final counts;
// monitors pop and compare on every sample pulse and every done rise.
module tb_stim_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WIDTH=2, HOLD=4
  logic       start_a, stop_a, resp_a;
  logic [1:0] mode_a;
  logic [1:0] vec_a;
  logic       vec_valid_a, sample_a, busy_a, done_a;
  logic [2:0] ones_a;
  int         rsel_a;

  // Instance B: WIDTH=3, HOLD=1
  logic       start_b, stop_b, resp_b;
  logic [1:0] mode_b;
  logic [2:0] vec_b;
  logic       vec_valid_b, sample_b, busy_b, done_b;
  logic [3:0] ones_b;
  int         rsel_b;

  stim_sequencer #(.WIDTH(2), .HOLD(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mode(mode_a),
    .resp(resp_a), .vec(vec_a), .vec_valid(vec_valid_a), .sample(sample_a),
    .busy(busy_a), .done(done_a), .ones_count(ones_a)
  );

  stim_sequencer #(.WIDTH(3), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mode(mode_b),
    .resp(resp_b), .vec(vec_b), .vec_valid(vec_valid_b), .sample(sample_b),
    .busy(busy_b), .done(done_b), .ones_count(ones_b)
  );

  // Unit under test models: 0 = AND, 1 = XOR, 2 = const 1, 3 = const 0
  always_comb begin
    case (rsel_a)
      0:       resp_a = &vec_a;
      1:       resp_a = ^vec_a;
      2:       resp_a = 1'b1;
      default: resp_a = 1'b0;
    endcase
    case (rsel_b)
      0:       resp_b = &vec_b;
      1:       resp_b = ^vec_b;
      2:       resp_b = 1'b1;
      default: resp_b = 1'b0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  int exp_vec_a[$];
  int exp_cnt_a[$];
  int exp_vec_b[$];
  int exp_cnt_b[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask

  // Monitor A
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_a) begin
        if (exp_vec_a.size() == 0) unexpected("a_sample_vec", int'(vec_a));
        else begin
          chk("a_sample_vec", int'(vec_a), exp_vec_a.pop_front());
          chk("a_sample_valid", int'(vec_valid_a), 1);
        end
      end
      if (done_a && !done_a_prev) begin
        if (exp_cnt_a.size() == 0) unexpected("a_done_count", int'(ones_a));
        else chk("a_done_count", int'(ones_a), exp_cnt_a.pop_front());
      end
    end
    done_a_prev <= done_a;
  end

  // Monitor B
  logic done_b_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_b) begin
        if (exp_vec_b.size() == 0) unexpected("b_sample_vec", int'(vec_b));
        else chk("b_sample_vec", int'(vec_b), exp_vec_b.pop_front());
      end
      if (done_b && !done_b_prev) begin
        if (exp_cnt_b.size() == 0) unexpected("b_done_count", int'(ones_b));
        else chk("b_done_count", int'(ones_b), exp_cnt_b.pop_front());
      end
    end
    done_b_prev <= done_b;
  end

  // Full run on A; checks busy after start and done latency of 16 cycles.
  task automatic run_a(input logic [1:0] m, input int rs, input int v0, input int v1,
                       input int v2, input int v3, input int cnt, input string tag);
    int cyc;
    exp_vec_a.push_back(v0); exp_vec_a.push_back(v1);
    exp_vec_a.push_back(v2); exp_vec_a.push_back(v3);
    exp_cnt_a.push_back(cnt);
    @(negedge clk);
    rsel_a = rs; mode_a = m; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk({tag, "_busy"}, int'(busy_a), 1);
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_latency"}, cyc, 16);
    $display("run %s mode=%0d cycles=%0d ones=%0d", tag, m, cyc, ones_a);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start_a = 0; stop_a = 0; mode_a = 2'b00; rsel_a = 0;
    start_b = 0; stop_b = 0; mode_b = 2'b00; rsel_b = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_a_outputs", int'({vec_a, vec_valid_a, sample_a, busy_a, done_a, ones_a}), 0);
    chk("rst_b_outputs", int'({vec_b, vec_valid_b, sample_b, busy_b, done_b, ones_b}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Binary up / Gray / binary down on A
    run_a(2'b00, 0, 0, 1, 2, 3, 1, "a_up_and");
    run_a(2'b01, 1, 0, 1, 3, 2, 2, "a_gray_xor");
    run_a(2'b11, 0, 3, 2, 1, 0, 1, "a_down_and");

    // Walking one on B, HOLD=1
    exp_vec_b.push_back(1); exp_vec_b.push_back(2); exp_vec_b.push_back(4);
    exp_cnt_b.push_back(3);
    @(negedge clk);
    rsel_b = 2; mode_b = 2'b10; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_first_vec", int'(vec_b), 1);
    chk("b_first_sample", int'(sample_b), 1);
    cyc = 0;
    while (!done_b && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b_done_latency", cyc, 3);
    $display("run b_walk mode=2 cycles=%0d ones=%0d", cyc, ones_b);

    // Stop on the second sample cycle of A
    exp_vec_a.push_back(0); exp_vec_a.push_back(1);
    @(negedge clk);
    rsel_a = 2; mode_a = 2'b00; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("a_stop_on_sample", int'(sample_a), 1);
    stop_a = 1'b1;
    @(posedge clk); #1;
    stop_a = 1'b0;
    chk("a_stop_busy", int'(busy_a), 0);
    chk("a_stop_done", int'(done_a), 0);
    chk("a_stop_vec", int'(vec_a), 0);
    chk("a_stop_partial", int'(ones_a), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("a_stop_stays_idle", int'({busy_a, done_a}), 0);
    $display("run a_stop ones=%0d", ones_a);

    // Reset mid-run with start in the same cycle
    @(negedge clk);
    rsel_a = 2; mode_a = 2'b00; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; start_a = 1'b1; mode_a = 2'b01;
    @(posedge clk); #1;
    rst = 1'b0; start_a = 1'b0;
    chk("a_rst_outputs", int'({vec_a, vec_valid_a, sample_a, busy_a, done_a, ones_a}), 0);
    @(posedge clk); #1;
    chk("a_rst_stays_idle", int'({busy_a, done_a}), 0);
    $display("run a_reset_mid_run busy=%0d", busy_a);
    run_a(2'b01, 1, 0, 1, 3, 2, 2, "a_after_rst");

    // Start held through DONE: restart, then mode/start changes mid-run ignored
    for (int k = 0; k < 2; k++) begin
      exp_vec_a.push_back(0); exp_vec_a.push_back(1);
      exp_vec_a.push_back(2); exp_vec_a.push_back(3);
      exp_cnt_a.push_back(1);
    end
    @(negedge clk);
    rsel_a = 0; mode_a = 2'b00; start_a = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("a_held_done_latency", cyc, 16);
    @(posedge clk); #1;
    chk("a_restart_done", int'(done_a), 0);
    chk("a_restart_busy", int'(busy_a), 1);
    chk("a_restart_cleared", int'(ones_a), 0);
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin
        start_a = 1'b1; mode_a = 2'b11;
      end else begin
        start_a = 1'b0;
      end
    end
    chk("a_restart_latency", cyc, 16);
    $display("run a_restart cycles=%0d ones=%0d", cyc, ones_a);

    repeat (3) @(posedge clk);
    #1;
    chk("a_vec_queue_empty", exp_vec_a.size(), 0);
    chk("a_cnt_queue_empty", exp_cnt_a.size(), 0);
    chk("b_vec_queue_empty", exp_vec_b.size(), 0);
    chk("b_cnt_queue_empty", exp_cnt_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Parametrised stimulus sequencer that drives an N-bit input vector into a combinational unit under test, one vector per programmable hold window. It supports four sequence modes and samples a 1-bit response at the end of each window, counting the ones. It replaces free-running testbench counters with a synthesizable, restartable block that can exercise a gate-level module exhaustively on hardware and report a truth-table signature.

## Interface
Parameters:
- WIDTH, default 2: vector width; must be at least 1.
- HOLD, default 4: clock cycles each vector is held; must be at least 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begins a sequence when the block is in IDLE or DONE.
- stop, input, 1: aborts a running sequence.
- mode, input, 2: sequence select, latched on an accepted start.
- resp, input, 1: response from the unit under test.
- vec, output, WIDTH: stimulus vector.
- vec_valid, output, 1: vec is a sequence vector (RUN state).
- sample, output, 1: high in the cycle resp is accumulated.
- busy, output, 1: high in RUN.
- done, output, 1: high while in DONE.
- ones_count, output, WIDTH+1: number of sampled resp=1 in the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - idx: WIDTH bits, vector index.
  - hcnt: counts 0..HOLD-1.
  - mode_q: 2 bits, latched mode.
- Vector count N:
  - mode 10: N = WIDTH.
  - all other modes: N = 2^WIDTH.
- Vector as a function of idx, combinational from registers:
  - 00 binary up: vec = idx.
  - 01 Gray: vec = idx ^ (idx >> 1).
  - 10 walking one: vec = 1 << idx.
  - 11 binary down: vec = ~idx.
- IDLE/DONE with start=1:
  - mode_q <= mode; idx <= 0; hcnt <= 0; ones_count <= 0.
  - Next state is RUN.
  - stop is ignored in IDLE and DONE.
- RUN:
  - vec_valid=1 and busy=1.
  - sample = (hcnt == HOLD-1).
  - Non-sample cycle: hcnt increments.
  - Sample cycle: ones_count <= ones_count + resp; hcnt <= 0.
    - If idx == N-1, next state is DONE.
    - Otherwise idx increments.
- stop in RUN:
  - Next state is IDLE.
  - resp is not accumulated that cycle, even on a sample cycle.
  - ones_count keeps its partial value.
  - done is never asserted for an aborted run.
- start in RUN is ignored. A change on mode while in RUN is ignored.
- Outputs outside RUN: vec=0, vec_valid=0, sample=0, busy=0. done=1 only in DONE.
- ones_count holds from DONE until the next accepted start.
- ones_count never wraps: its maximum is 2^WIDTH, which fits in WIDTH+1 bits.

## Timing
- Reset: state IDLE; idx, hcnt, mode_q, ones_count = 0. All outputs are 0.
- rst has priority over start and stop in every state. Reset mid-run returns the block to IDLE on the next edge with no done pulse.
- If start is sampled at edge 0:
  - busy=1 and vec is the first vector from edge 0 to edge 1.
  - Vector k (0-based) is valid from edge k·HOLD to edge (k+1)·HOLD.
  - sample is high in the last cycle of each window.
- done rises at edge N·HOLD, the cycle after the final sample.
- Total run length is N·HOLD cycles. There are no idle cycles between vectors.
- HOLD=1: sample is high in every RUN cycle and vec changes every cycle.
- resp is sampled at the rising edge that ends a sample cycle. The unit under test must settle within HOLD cycles.
- Restart from DONE: a start sampled while done=1 clears ones_count and done at the same edge.

## Test plan
- WIDTH=2, HOLD=4, mode 00, resp = vec[1]&vec[0] -> vec sequence 0,1,2,3, each held 4 cycles; four sample pulses; done at cycle 16 after start; ones_count=1.
- mode 01 with resp=vec[0]^vec[1] -> vec sequence 0,1,3,2; ones_count=2. mode 11 -> vec sequence 3,2,1,0.
- WIDTH=3, HOLD=1, mode 10, resp tied to 1 -> vec sequence 001,010,100 on consecutive cycles; ones_count=3; done at cycle 3.
- WIDTH=2, HOLD=4, mode 00, resp=1, stop asserted on the second sample cycle -> IDLE; ones_count=1; done stays 0; vec=0.
- rst during RUN, then start with mode 01 in the same cycle as rst -> block stays IDLE with all outputs 0; a later start runs cleanly from idx 0.
- start held high through DONE -> restart at the edge after done rises; ones_count cleared; start pulses during RUN have no effect.
